// File: rtl/req_arbiter4.sv
// Four-way round-robin arbiter for a shared resource: one grant at a time,
// released on done, on requester abandon, or forcibly after TIMEOUT cycles.
module req_arbiter4 #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       any_req,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_ptr;
    logic [3:0]       r_gnt;
    logic [1:0]       r_gnt_id;
    logic             r_busy;
    logic             r_timeout_err;

    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_abandon;
    logic             w_at_limit;
    logic             w_exit;

    assign any_req     = |req;
    assign gnt         = r_gnt;
    assign gnt_id      = r_gnt_id;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

    // Scan downward so the candidate closest to ptr+1 is the last to be written.
    always_comb begin
        w_win = 2'd0;
        w_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = 2'(r_ptr + 2'(k) + 2'd1);
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    assign w_abandon  = ~req[r_gnt_id];
    assign w_at_limit = (r_cnt == CNT_LAST);
    assign w_exit     = done | w_abandon | w_at_limit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_ptr         <= 2'd3;
            r_gnt         <= '0;
            r_gnt_id      <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timeout_err <= 1'b0;
                    if (any_req) begin
                        r_state  <= S_GRANT;
                        r_gnt    <= 4'(4'b0001 << w_win);
                        r_gnt_id <= w_win;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                S_GRANT: begin
                    r_cnt <= CNT_W'(r_cnt + 1'b1);
                    if (w_exit) begin
                        r_state       <= S_RELEASE;
                        r_gnt         <= '0;
                        r_busy        <= 1'b0;
                        r_ptr         <= r_gnt_id;
                        // Forced release only when neither done nor abandon explains the exit.
                        r_timeout_err <= w_at_limit & ~done & ~w_abandon;
                    end
                end
                S_RELEASE: begin
                    r_state       <= S_IDLE;
                    r_timeout_err <= 1'b0;
                    r_gnt         <= '0;
                    r_busy        <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_gnt         <= '0;
                    r_busy        <= 1'b0;
                    r_timeout_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
